// File: rtl/hack_dbg_pkg.sv
// rtl/hack_dbg_pkg.sv - shared encodings for the Hack CPU debug controller
//
// Purpose : command opcodes, controller state enum, halt-cause codes and a
//           helper that sizes the breakpoint slot index.
// Ports   : none (package).
// Config  : HACK_DBG_BP_EN enables breakpoint slots (see hack_bp_match).
package hack_dbg_pkg;

   typedef enum logic [1:0] {
      OP_RUN    = 2'b00,
      OP_HALT   = 2'b01,
      OP_STEP   = 2'b10,
      OP_SET_BP = 2'b11
   } cmd_op_t;

   typedef enum logic [1:0] {
      ST_HALTED = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2
   } state_t;

   localparam logic [1:0] CAUSE_RESET = 2'd0;
   localparam logic [1:0] CAUSE_HALT  = 2'd1;
   localparam logic [1:0] CAUSE_STEP  = 2'd2;
   localparam logic [1:0] CAUSE_BP    = 2'd3;

   // Slot index width; a single slot still needs a 1-bit index.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hack_debug_ctrl_if.sv
// rtl/hack_debug_ctrl_if.sv - debug command channel between host and controller
//
// Purpose : bundles the command handshake and its payload.
// Signals : cmd_valid/cmd_ready handshake, cmd_op opcode, cmd_idx slot,
//           cmd_addr breakpoint PC, cmd_bp_en slot enable.
// Modports: master (host side), slave (controller side).
// Config  : HACK_DBG_BP_EN (payload is ignored when breakpoints are disabled).
interface hack_debug_ctrl_if #(
   parameter int PC_W  = 15,
   parameter int IDX_W = 2
);
   import hack_dbg_pkg::*;

   logic             cmd_valid;
   logic             cmd_ready;
   cmd_op_t          cmd_op;
   logic [IDX_W-1:0] cmd_idx;
   logic [PC_W-1:0]  cmd_addr;
   logic             cmd_bp_en;

   modport master (
      output cmd_valid, cmd_op, cmd_idx, cmd_addr, cmd_bp_en,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_idx, cmd_addr, cmd_bp_en,
      output cmd_ready
   );
endinterface

// File: rtl/hack_bp_match.sv
// rtl/hack_bp_match.sv - breakpoint slot storage and lowest-index PC matcher
//
// Purpose : holds NUM_BP {address, enable} slots and flags a combinational
//           match of i_pc against any enabled slot, reporting the lowest index.
// Ports   : clk, reset (sync, active-high); i_we/i_idx/i_addr/i_en slot write;
//           i_pc current PC; o_hit match flag; o_hit_idx lowest matching slot.
// Config  : HACK_DBG_BP_EN defined -> slots and comparators present;
//           undefined -> no storage, o_hit and o_hit_idx tied low.
module hack_bp_match
   import hack_dbg_pkg::*;
#(
   parameter int PC_W   = 15,
   parameter int NUM_BP = 4,
   parameter int IDX_W  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_idx,
   input  logic [PC_W-1:0]  i_addr,
   input  logic             i_en,
   input  logic [PC_W-1:0]  i_pc,
   output logic             o_hit,
   output logic [IDX_W-1:0] o_hit_idx
);

`ifdef HACK_DBG_BP_EN
   logic [PC_W-1:0]   r_addr [NUM_BP];
   logic [NUM_BP-1:0] r_en;

   // An index beyond NUM_BP-1 matches no slot, so the write is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_en <= '0;
         for (int i = 0; i < NUM_BP; i++) r_addr[i] <= '0;
      end else if (i_we) begin
         for (int i = 0; i < NUM_BP; i++) begin
            if (i_idx == IDX_W'(i)) begin
               r_addr[i] <= i_addr;
               r_en[i]   <= i_en;
            end
         end
      end
   end

   // Scan high to low so the lowest matching slot is the last one written.
   always_comb begin
      o_hit     = 1'b0;
      o_hit_idx = '0;
      for (int i = NUM_BP - 1; i >= 0; i--) begin
         if (r_en[i] && (r_addr[i] == i_pc)) begin
            o_hit     = 1'b1;
            o_hit_idx = IDX_W'(i);
         end
      end
   end
`else
   logic w_unused_bp;
   assign w_unused_bp = ^{clk, reset, i_we, i_idx, i_addr, i_en, i_pc};
   assign o_hit       = 1'b0;
   assign o_hit_idx   = '0;
`endif

endmodule

// File: rtl/hack_debug_ctrl.sv
// rtl/hack_debug_ctrl.sv - run/halt/step debug controller for a Hack CPU
//
// Purpose : gates the CPU clock enable, accepts RUN/HALT/STEP/SET_BP commands,
//           halts on PC breakpoints and counts executed cycles.
// Ports   : clk, reset (sync, active-high); i_pc CPU program counter;
//           cmd (hack_debug_ctrl_if.slave) command channel;
//           o_cpu_en CPU clock enable; o_halted; o_halt_cause;
//           o_bp_hit_idx last breakpoint slot; o_cycle_count executed cycles.
// Config  : HACK_DBG_BP_EN enables breakpoint slots in hack_bp_match.
module hack_debug_ctrl
   import hack_dbg_pkg::*;
#(
   parameter int PC_W      = 15,
   parameter int NUM_BP    = 4,
   parameter int CNT_W     = 32,
   parameter int RESET_RUN = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [PC_W-1:0]            i_pc,
   hack_debug_ctrl_if.slave           cmd,
   output logic                       o_cpu_en,
   output logic                       o_halted,
   output logic [1:0]                 o_halt_cause,
   output logic [idx_w(NUM_BP)-1:0]   o_bp_hit_idx,
   output logic [CNT_W-1:0]           o_cycle_count
);

   localparam int IDX_W = idx_w(NUM_BP);

   state_t           r_state;
   state_t           w_next;
   logic             r_first_run;
   logic [1:0]       r_cause;
   logic [IDX_W-1:0] r_bp_idx;
   logic [CNT_W-1:0] r_cnt;

   cmd_op_t          w_op;
   logic             w_accept;
   logic             w_hit;
   logic             w_bp;
   logic [IDX_W-1:0] w_hit_idx;

   assign w_op     = cmd.cmd_op;
   assign w_accept = cmd.cmd_valid && cmd.cmd_ready;

   hack_bp_match #(
      .PC_W   (PC_W),
      .NUM_BP (NUM_BP),
      .IDX_W  (IDX_W)
   ) u_bp_match (
      .clk       (clk),
      .reset     (reset),
      .i_we      (w_accept && (w_op == OP_SET_BP)),
      .i_idx     (cmd.cmd_idx),
      .i_addr    (cmd.cmd_addr),
      .i_en      (cmd.cmd_bp_en),
      .i_pc      (i_pc),
      .o_hit     (w_hit),
      .o_hit_idx (w_hit_idx)
   );

   // Matching is masked on the first RUN cycle after a halt so that resuming
   // from a breakpoint PC executes that instruction instead of re-halting.
   assign w_bp = w_hit && (r_state == ST_RUN) && !r_first_run;

   always_ff @(posedge clk) begin
      if (reset) r_state <= (RESET_RUN != 0) ? ST_RUN : ST_HALTED;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_HALTED: begin
            if (w_accept && (w_op == OP_RUN))  w_next = ST_RUN;
            if (w_accept && (w_op == OP_STEP)) w_next = ST_STEP;
         end
         ST_RUN: begin
            // Breakpoint takes priority over a same-cycle HALT.
            if (w_bp || (w_accept && (w_op == OP_HALT))) w_next = ST_HALTED;
         end
         ST_STEP: w_next = ST_HALTED;
         default: w_next = ST_HALTED;
      endcase
   end

   always_comb begin
      o_cpu_en      = 1'b0;
      cmd.cmd_ready = 1'b0;
      if (!reset) begin
         case (r_state)
            ST_HALTED: cmd.cmd_ready = 1'b1;
            ST_RUN: begin
               cmd.cmd_ready = 1'b1;
               o_cpu_en      = !w_bp;
            end
            ST_STEP:   o_cpu_en = 1'b1;
            default:   o_cpu_en = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_first_run <= 1'b0;
         r_cause     <= CAUSE_RESET;
         r_bp_idx    <= '0;
         r_cnt       <= '0;
      end else begin
         r_first_run <= (r_state == ST_HALTED) && (w_next == ST_RUN);
         if (o_cpu_en) r_cnt <= r_cnt + 1'b1;
         if (r_state == ST_STEP) begin
            r_cause <= CAUSE_STEP;
         end else if (w_bp) begin
            r_cause  <= CAUSE_BP;
            r_bp_idx <= w_hit_idx;
         end else if ((r_state == ST_RUN) && w_accept && (w_op == OP_HALT)) begin
            r_cause <= CAUSE_HALT;
         end
      end
   end

   assign o_halted      = (r_state == ST_HALTED);
   assign o_halt_cause  = r_cause;
   assign o_bp_hit_idx  = r_bp_idx;
   assign o_cycle_count = r_cnt;

endmodule

// File: tb/tb_hack_debug_ctrl.sv
// tb/tb_hack_debug_ctrl.sv - scoreboard bench for hack_debug_ctrl
module tb_hack_debug_ctrl;
   import hack_dbg_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [14:0] pc = '0;
   logic        o_cpu_en;
   logic        o_halted;
   logic [1:0]  o_halt_cause;
   logic [1:0]  o_bp_hit_idx;
   logic [7:0]  o_cycle_count;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_cnt = 0;

   typedef struct {
      bit         chk;
      bit         en;
      bit         hlt;
      bit         rdy;
      logic [1:0] cause;
      logic [1:0] bpi;
      logic [7:0] cnt;
   } exp_t;

   exp_t q[$];

   hack_debug_ctrl_if #(.PC_W(15), .IDX_W(2)) bus ();

   hack_debug_ctrl #(
      .PC_W(15), .NUM_BP(4), .CNT_W(8), .RESET_RUN(1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_pc          (pc),
      .cmd           (bus),
      .o_cpu_en      (o_cpu_en),
      .o_halted      (o_halted),
      .o_halt_cause  (o_halt_cause),
      .o_bp_hit_idx  (o_bp_hit_idx),
      .o_cycle_count (o_cycle_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; the expected outputs for that same cycle go to the scoreboard.
   task automatic row(input bit rst, input bit v, input cmd_op_t op, input logic [1:0] idx,
                      input logic [14:0] addr, input bit bpen, input logic [14:0] p,
                      input bit e_en, input bit e_hlt, input bit e_rdy,
                      input logic [1:0] e_cause, input logic [1:0] e_bpi);
      exp_t e;
      @(posedge clk);
      #1;
      reset         = rst;
      bus.cmd_valid = v;
      bus.cmd_op    = op;
      bus.cmd_idx   = idx;
      bus.cmd_addr  = addr;
      bus.cmd_bp_en = bpen;
      pc            = p;
      e.chk   = !rst;
      e.en    = e_en;
      e.hlt   = e_hlt;
      e.rdy   = e_rdy;
      e.cause = e_cause;
      e.bpi   = e_bpi;
      e.cnt   = 8'(exp_cnt);
      q.push_back(e);
      if (rst)       exp_cnt = 0;
      else if (e_en) exp_cnt = (exp_cnt + 1) % 256;
   endtask

   task automatic idle(input logic [14:0] p, input bit e_en, input bit e_hlt, input bit e_rdy,
                       input logic [1:0] e_cause, input logic [1:0] e_bpi);
      row(0, 0, OP_RUN, 2'd0, 15'd0, 0, p, e_en, e_hlt, e_rdy, e_cause, e_bpi);
   endtask

   task automatic cmd(input cmd_op_t op, input logic [1:0] idx, input logic [14:0] addr,
                      input bit bpen, input logic [14:0] p, input bit e_en, input bit e_hlt,
                      input bit e_rdy, input logic [1:0] e_cause, input logic [1:0] e_bpi);
      row(0, 1, op, idx, addr, bpen, p, e_en, e_hlt, e_rdy, e_cause, e_bpi);
   endtask

   task automatic rst_cycle();
      row(1, 1, OP_HALT, 2'd0, 15'd0, 0, 15'd0, 0, 0, 0, 2'd0, 2'd0);
   endtask

   // Monitor: compares DUT outputs against the scoreboard once per cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("cpu_en", 32'(o_cpu_en), 32'(e.en));
            check("cmd_ready", 32'(bus.cmd_ready), 32'(e.rdy));
            if (e.chk) begin
               check("halted", 32'(o_halted), 32'(e.hlt));
               check("halt_cause", 32'(o_halt_cause), 32'(e.cause));
               check("bp_hit_idx", 32'(o_bp_hit_idx), 32'(e.bpi));
               check("cycle_count", 32'(o_cycle_count), 32'(e.cnt));
            end
         end
      end
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
      $finish;
   end

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_RUN;
      bus.cmd_idx   = '0;
      bus.cmd_addr  = '0;
      bus.cmd_bp_en = 1'b0;

      // Reset, then free-run from reset.
      rst_cycle();
      rst_cycle();
      for (int i = 0; i < 5; i++) idle(15'(i), 1, 0, 1, 2'd0, 2'd0);

      // HALT in RUN executes the accepting cycle; HALT in HALTED is ignored.
      cmd(OP_HALT, 2'd0, 15'd0, 0, 15'd5, 1, 0, 1, 2'd0, 2'd0);
      idle(15'd6, 0, 1, 1, 2'd1, 2'd0);
      cmd(OP_HALT, 2'd0, 15'd0, 0, 15'd6, 0, 1, 1, 2'd1, 2'd0);

      // Single step; a RUN offered during STEP is not accepted.
      cmd(OP_STEP, 2'd0, 15'd0, 0, 15'd6, 0, 1, 1, 2'd1, 2'd0);
      cmd(OP_RUN,  2'd0, 15'd0, 0, 15'd6, 1, 0, 0, 2'd1, 2'd0);
      idle(15'd7, 0, 1, 1, 2'd2, 2'd0);
      idle(15'd7, 0, 1, 1, 2'd2, 2'd0);

      // Resume; RUN while running is a no-op.
      cmd(OP_RUN, 2'd0, 15'd0, 0, 15'd7, 0, 1, 1, 2'd2, 2'd0);
      idle(15'd7, 1, 0, 1, 2'd2, 2'd0);
      cmd(OP_RUN, 2'd0, 15'd0, 0, 15'd8, 1, 0, 1, 2'd2, 2'd0);

`ifdef HACK_DBG_BP_EN
      // Breakpoint at 0x10 in slot 2.
      cmd(OP_SET_BP, 2'd2, 15'h10, 1, 15'd9, 1, 0, 1, 2'd2, 2'd0);
      for (int i = 10; i < 16; i++) idle(15'(i), 1, 0, 1, 2'd2, 2'd0);
      idle(15'h10, 0, 0, 1, 2'd2, 2'd0);
      idle(15'h10, 0, 1, 1, 2'd3, 2'd2);
      // Resume from the breakpoint PC executes it, then re-halts on return.
      cmd(OP_RUN, 2'd0, 15'd0, 0, 15'h10, 0, 1, 1, 2'd3, 2'd2);
      idle(15'h10, 1, 0, 1, 2'd3, 2'd2);
      idle(15'h11, 1, 0, 1, 2'd3, 2'd2);
      idle(15'h12, 1, 0, 1, 2'd3, 2'd2);
      idle(15'h10, 0, 0, 1, 2'd3, 2'd2);
      idle(15'h10, 0, 1, 1, 2'd3, 2'd2);
      // Slots 0 and 3 on 0x5, slot 2 disabled; HALT on the match cycle.
      cmd(OP_SET_BP, 2'd0, 15'h5, 1, 15'h10, 0, 1, 1, 2'd3, 2'd2);
      cmd(OP_SET_BP, 2'd3, 15'h5, 1, 15'h10, 0, 1, 1, 2'd3, 2'd2);
      cmd(OP_SET_BP, 2'd2, 15'h10, 0, 15'h10, 0, 1, 1, 2'd3, 2'd2);
      cmd(OP_RUN, 2'd0, 15'd0, 0, 15'd4, 0, 1, 1, 2'd3, 2'd2);
      idle(15'd4, 1, 0, 1, 2'd3, 2'd2);
      cmd(OP_HALT, 2'd0, 15'd0, 0, 15'd5, 0, 0, 1, 2'd3, 2'd2);
      idle(15'd5, 0, 1, 1, 2'd3, 2'd0);
      // STEP ignores the breakpoint sitting on the current PC.
      cmd(OP_STEP, 2'd0, 15'd0, 0, 15'd5, 0, 1, 1, 2'd3, 2'd0);
      idle(15'd5, 1, 0, 0, 2'd3, 2'd0);
      idle(15'd5, 0, 1, 1, 2'd2, 2'd0);
`else
      // Without breakpoint support SET_BP is accepted and has no effect.
      cmd(OP_SET_BP, 2'd2, 15'h10, 1, 15'd9, 1, 0, 1, 2'd2, 2'd0);
      idle(15'h10, 1, 0, 1, 2'd2, 2'd0);
      idle(15'h10, 1, 0, 1, 2'd2, 2'd0);
      cmd(OP_HALT, 2'd0, 15'd0, 0, 15'h11, 1, 0, 1, 2'd2, 2'd0);
      idle(15'h11, 0, 1, 1, 2'd1, 2'd0);
      cmd(OP_STEP, 2'd0, 15'd0, 0, 15'h11, 0, 1, 1, 2'd1, 2'd0);
      idle(15'h11, 1, 0, 0, 2'd1, 2'd0);
      idle(15'h11, 0, 1, 1, 2'd2, 2'd0);
`endif

      // Run long enough for the 8-bit cycle counter to wrap.
      cmd(OP_RUN, 2'd0, 15'd0, 0, 15'h200, 0, 1, 1, 2'd2, 2'd0);
      while (exp_cnt < 270 && exp_cnt != 4) idle(15'h200, 1, 0, 1, 2'd2, 2'd0);

      // Reset mid-RUN: slots, cause and counter cleared, running again.
      rst_cycle();
      idle(15'd5, 1, 0, 1, 2'd0, 2'd0);
      idle(15'd5, 1, 0, 1, 2'd0, 2'd0);

      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
      $finish;
   end

endmodule
